// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cpu_pkg
//  Description : Opcode constants and sequencer state type shared by the
//                IF/ID micro-op sequencer and the control decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int OPC_W_DEF = 5;

  // First-part opcodes and their second-part (+1) companions
  localparam logic [OPC_W_DEF-1:0] OPC_NOP   = 5'b00000;
  localparam logic [OPC_W_DEF-1:0] OPC_CALL  = 5'b11000;
  localparam logic [OPC_W_DEF-1:0] OPC_CALL2 = 5'b11001;
  localparam logic [OPC_W_DEF-1:0] OPC_RET   = 5'b11010;
  localparam logic [OPC_W_DEF-1:0] OPC_RET2  = 5'b11011;
  localparam logic [OPC_W_DEF-1:0] OPC_RTI   = 5'b11100;
  localparam logic [OPC_W_DEF-1:0] OPC_RTI2  = 5'b11101;
  localparam logic [OPC_W_DEF-1:0] OPC_INT   = 5'b11110;
  localparam logic [OPC_W_DEF-1:0] OPC_INT2  = 5'b11111;

  // Sequencer states: pass-through, owed second part, owed interrupt
  // second part, and flush bubble emission
  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    PART2 = 2'd1,
    INT1  = 2'd2,
    FLUSH = 2'd3
  } seq_state_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/micro_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : micro_op_sequencer
//  Description : Registered IF/ID boundary sequencer. Passes fetched opcodes
//                to decode one cycle later, expands CALL/RET/RTI into their
//                second micro-op, injects the two-part interrupt sequence at
//                instruction boundaries and emits flush bubbles.
//  Revision    : 1.0 - initial release
// ============================================================================
module micro_op_sequencer
  import cpu_pkg::*;
#(
  parameter int               OPC_W         = 5,
  parameter logic [OPC_W-1:0] CALL_OPC      = OPC_CALL,
  parameter logic [OPC_W-1:0] RET_OPC       = OPC_RET,
  parameter logic [OPC_W-1:0] RTI_OPC       = OPC_RTI,
  parameter logic [OPC_W-1:0] INT_OPC       = OPC_INT,
  parameter logic [OPC_W-1:0] NOP_OPC       = OPC_NOP,
  parameter int               FLUSH_BUBBLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fetchValid,
  input  logic [OPC_W-1:0] fetchOpcode,
  input  logic             stall,
  input  logic             flush,
  input  logic             intReq,
  output logic             fetchStall,
  output logic             issueValid,
  output logic [OPC_W-1:0] issueOpcode,
  output logic             issuePart,
  output logic             bubble,
  output logic             intAck
);

  // The flush edge itself produces the first bubble, so the counter
  // only has to cover the remaining ones.
  localparam logic [3:0] CNT_RELOAD = 4'(FLUSH_BUBBLES - 1);

  seq_state_t       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             int_pend_q, int_pend_d;
  logic             issue_valid_q, issue_valid_d;
  logic [OPC_W-1:0] issue_opcode_q, issue_opcode_d;
  logic             issue_part_q, issue_part_d;
  logic             bubble_q, bubble_d;
  logic             int_ack_q, int_ack_d;
  logic             take_int;
  logic             fetch_two_part;

  assign take_int       = (state_q == ISSUE) && int_pend_q && !stall && !flush;
  assign fetch_two_part = (fetchOpcode == CALL_OPC) || (fetchOpcode == RET_OPC) ||
                          (fetchOpcode == RTI_OPC);

  // Fetch is held while a second part is owed or an interrupt is injected;
  // flush is left out because fetch is redirecting anyway.
  assign fetchStall = stall || (state_q == PART2) || (state_q == INT1) || take_int;

  // Next-state and next-output computation: flush > stall > normal
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    issue_valid_d  = issue_valid_q;
    issue_opcode_d = issue_opcode_q;
    issue_part_d   = issue_part_q;
    bubble_d       = bubble_q;
    int_ack_d      = int_ack_q;
    // A repeat request while pending merges into the same interrupt
    int_pend_d     = int_pend_q || intReq;

    if (flush) begin
      state_d        = FLUSH;
      cnt_d          = CNT_RELOAD;
      issue_valid_d  = 1'b0;
      issue_opcode_d = NOP_OPC;
      issue_part_d   = 1'b0;
      bubble_d       = 1'b1;
      int_ack_d      = 1'b0;
    end else if (!stall) begin
      case (state_q)
        PART2: begin
          issue_valid_d  = 1'b1;
          issue_opcode_d = issue_opcode_q + 1'b1;
          issue_part_d   = 1'b1;
          bubble_d       = 1'b0;
          int_ack_d      = 1'b0;
          state_d        = ISSUE;
        end
        INT1: begin
          issue_valid_d  = 1'b1;
          issue_opcode_d = INT_OPC + 1'b1;
          issue_part_d   = 1'b1;
          bubble_d       = 1'b0;
          int_ack_d      = 1'b1;
          int_pend_d     = 1'b0;
          state_d        = ISSUE;
        end
        FLUSH: begin
          if (cnt_q != 4'd0) begin
            cnt_d          = cnt_q - 4'd1;
            issue_valid_d  = 1'b0;
            issue_opcode_d = NOP_OPC;
            issue_part_d   = 1'b0;
            bubble_d       = 1'b1;
            int_ack_d      = 1'b0;
          end
        end
        default: ;
      endcase

      // Pass-through: normal ISSUE cycles and the last FLUSH cycle, whose
      // redirected fetch must not be lost (take_int is already false there).
      if ((state_q == ISSUE) || ((state_q == FLUSH) && (cnt_q == 4'd0))) begin
        issue_part_d = 1'b0;
        bubble_d     = 1'b0;
        int_ack_d    = 1'b0;
        state_d      = ISSUE;
        if (take_int) begin
          issue_valid_d  = 1'b1;
          issue_opcode_d = INT_OPC;
          state_d        = INT1;
        end else if (fetchValid) begin
          issue_valid_d  = 1'b1;
          issue_opcode_d = fetchOpcode;
          if (fetch_two_part) state_d = PART2;
        end else begin
          issue_valid_d  = 1'b0;
          issue_opcode_d = NOP_OPC;
        end
      end
    end
  end

  // State, counter, pending latch and registered issue outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ISSUE;
      cnt_q          <= 4'd0;
      int_pend_q     <= 1'b0;
      issue_valid_q  <= 1'b0;
      issue_opcode_q <= NOP_OPC;
      issue_part_q   <= 1'b0;
      bubble_q       <= 1'b0;
      int_ack_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      int_pend_q     <= int_pend_d;
      issue_valid_q  <= issue_valid_d;
      issue_opcode_q <= issue_opcode_d;
      issue_part_q   <= issue_part_d;
      bubble_q       <= bubble_d;
      int_ack_q      <= int_ack_d;
    end
  end

  assign issueValid  = issue_valid_q;
  assign issueOpcode = issue_opcode_q;
  assign issuePart   = issue_part_q;
  assign bubble      = bubble_q;
  assign intAck      = int_ack_q;

endmodule : micro_op_sequencer
`default_nettype wire

// File: tb/tb_micro_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_micro_op_sequencer
//  Description : Self-checking bench: directed vector table for the
//                multi-cycle corner cases, async reset sequence, then random
//                stimulus against a queue-based behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_micro_op_sequencer;

  localparam int B = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fetchValid;
  logic [4:0] fetchOpcode;
  logic       stall;
  logic       flush;
  logic       intReq;
  logic       fetchStall;
  logic       issueValid;
  logic [4:0] issueOpcode;
  logic       issuePart;
  logic       bubble;
  logic       intAck;

  int checks   = 0;
  int failures = 0;

  micro_op_sequencer #(.OPC_W(5), .FLUSH_BUBBLES(B)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetchValid  (fetchValid),
    .fetchOpcode (fetchOpcode),
    .stall       (stall),
    .flush       (flush),
    .intReq      (intReq),
    .fetchStall  (fetchStall),
    .issueValid  (issueValid),
    .issueOpcode (issueOpcode),
    .issuePart   (issuePart),
    .bubble      (bubble),
    .intAck      (intAck)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [4:0] op;
    bit         is_int;
  } owed_t;

  owed_t      owed[$];      // micro-ops still owed before fetch resumes
  bit         m_pend;       // interrupt waiting to be injected
  bit         m_flushing;   // bubble phase after a flush
  int         m_left;       // bubbles still to be emitted after the current one
  logic       m_valid, m_part, m_bub, m_ack;
  logic [4:0] m_op;

  function automatic bit is_two_part(logic [4:0] op);
    return (op == 5'b11000) || (op == 5'b11010) || (op == 5'b11100);
  endfunction

  task automatic model_reset();
    owed.delete();
    m_pend = 0; m_flushing = 0; m_left = 0;
    m_valid = 0; m_part = 0; m_bub = 0; m_ack = 0; m_op = 5'b00000;
  endtask

  function automatic bit model_take();
    return !m_flushing && (owed.size() == 0) && m_pend && !stall && !flush;
  endfunction

  function automatic logic model_fstall();
    return stall || (owed.size() != 0) || model_take();
  endfunction

  task automatic set_out(logic v, logic [4:0] op, logic p, logic b, logic a);
    m_valid = v; m_op = op; m_part = p; m_bub = b; m_ack = a;
  endtask

  task automatic model_edge();
    bit    take;
    bit    pend_next;
    owed_t o;
    take      = model_take();
    pend_next = m_pend || intReq;
    if (flush) begin
      owed.delete();
      m_flushing = 1;
      m_left     = B - 1;
      set_out(0, 5'b00000, 0, 1, 0);
    end else if (stall) begin
      // everything holds
    end else if (owed.size() != 0) begin
      o = owed.pop_front();
      set_out(1, o.op, 1, 0, o.is_int);
      if (o.is_int) pend_next = 0;
    end else if (m_flushing && m_left > 0) begin
      m_left = m_left - 1;
      set_out(0, 5'b00000, 0, 1, 0);
    end else begin
      m_flushing = 0;
      if (take) begin
        set_out(1, 5'b11110, 0, 0, 0);
        owed.push_back('{op: 5'b11111, is_int: 1'b1});
      end else if (fetchValid) begin
        set_out(1, fetchOpcode, 0, 0, 0);
        if (is_two_part(fetchOpcode))
          owed.push_back('{op: fetchOpcode + 5'd1, is_int: 1'b0});
      end else begin
        set_out(0, 5'b00000, 0, 0, 0);
      end
    end
    m_pend = pend_next;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] outs();
    return {issueValid, issueOpcode, issuePart, bubble, intAck};
  endfunction

  function automatic logic [8:0] mouts();
    return {m_valid, m_op, m_part, m_bub, m_ack};
  endfunction

  // Drive one cycle's inputs (called just after a falling edge), check the
  // combinational stall before the rising edge and the registered outputs
  // at the following falling edge against the model.
  task automatic step(logic fv, logic [4:0] op, logic st, logic fl, logic ir,
                      string tag);
    fetchValid = fv; fetchOpcode = op; stall = st; flush = fl; intReq = ir;
    #1;
    chk({tag, ".model_fetchStall"}, 32'(fetchStall), 32'(model_fstall()));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk({tag, ".model_outs"}, 32'(outs()), 32'(mouts()));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       fv;
    logic [4:0] op;
    logic       st, fl, ir;
    logic       efs;
    logic       ev;
    logic [4:0] eop;
    logic       ep, eb, ea;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic fv, logic [4:0] op, logic st, logic fl,
                              logic ir, logic efs, logic ev, logic [4:0] eop,
                              logic ep, logic eb, logic ea);
    vec_t v;
    v.fv = fv; v.op = op; v.st = st; v.fl = fl; v.ir = ir; v.efs = efs;
    v.ev = ev; v.eop = eop; v.ep = ep; v.eb = eb; v.ea = ea;
    return v;
  endfunction

  initial begin
    // ADD, CALL, SUB: CALL expands, fetch held once
    vecs.push_back(mk(1, 5'b01001, 0, 0, 0,  0, 1, 5'b01001, 0, 0, 0));
    vecs.push_back(mk(1, 5'b11000, 0, 0, 0,  0, 1, 5'b11000, 0, 0, 0));
    vecs.push_back(mk(1, 5'b01010, 0, 0, 0,  1, 1, 5'b11001, 1, 0, 0));
    vecs.push_back(mk(1, 5'b01010, 0, 0, 0,  0, 1, 5'b01010, 0, 0, 0));
    vecs.push_back(mk(0, 5'b00000, 0, 0, 0,  0, 0, 5'b00000, 0, 0, 0));
    // interrupt pulse while RET part 0 is on the output
    vecs.push_back(mk(1, 5'b11010, 0, 0, 0,  0, 1, 5'b11010, 0, 0, 0));
    vecs.push_back(mk(1, 5'b01011, 0, 0, 1,  1, 1, 5'b11011, 1, 0, 0));
    vecs.push_back(mk(1, 5'b01011, 0, 0, 0,  1, 1, 5'b11110, 0, 0, 0));
    vecs.push_back(mk(1, 5'b01011, 0, 0, 0,  1, 1, 5'b11111, 1, 0, 1));
    vecs.push_back(mk(1, 5'b01011, 0, 0, 0,  0, 1, 5'b01011, 0, 0, 0));
    vecs.push_back(mk(0, 5'b00000, 0, 0, 0,  0, 0, 5'b00000, 0, 0, 0));
    // flush while CALL part 2 is owed: two bubbles, then fetch
    vecs.push_back(mk(1, 5'b11000, 0, 0, 0,  0, 1, 5'b11000, 0, 0, 0));
    vecs.push_back(mk(1, 5'b01100, 0, 1, 0,  1, 0, 5'b00000, 0, 1, 0));
    vecs.push_back(mk(1, 5'b01100, 0, 0, 0,  0, 0, 5'b00000, 0, 1, 0));
    vecs.push_back(mk(1, 5'b01100, 0, 0, 0,  0, 1, 5'b01100, 0, 0, 0));
    vecs.push_back(mk(0, 5'b00000, 0, 0, 0,  0, 0, 5'b00000, 0, 0, 0));
    // flush during INT1: interrupt retaken after the bubbles
    vecs.push_back(mk(0, 5'b00000, 0, 0, 1,  0, 0, 5'b00000, 0, 0, 0));
    vecs.push_back(mk(0, 5'b00000, 0, 0, 0,  1, 1, 5'b11110, 0, 0, 0));
    vecs.push_back(mk(0, 5'b00000, 0, 1, 0,  1, 0, 5'b00000, 0, 1, 0));
    vecs.push_back(mk(0, 5'b00000, 0, 0, 0,  0, 0, 5'b00000, 0, 1, 0));
    vecs.push_back(mk(0, 5'b00000, 0, 0, 0,  0, 0, 5'b00000, 0, 0, 0));
    vecs.push_back(mk(0, 5'b00000, 0, 0, 0,  1, 1, 5'b11110, 0, 0, 0));
    vecs.push_back(mk(0, 5'b00000, 0, 0, 0,  1, 1, 5'b11111, 1, 0, 1));
    vecs.push_back(mk(0, 5'b00000, 0, 0, 0,  0, 0, 5'b00000, 0, 0, 0));
    // stall held three cycles with CALL part 2 owed
    vecs.push_back(mk(1, 5'b11000, 0, 0, 0,  0, 1, 5'b11000, 0, 0, 0));
    vecs.push_back(mk(1, 5'b01101, 1, 0, 0,  1, 1, 5'b11000, 0, 0, 0));
    vecs.push_back(mk(1, 5'b01101, 1, 0, 0,  1, 1, 5'b11000, 0, 0, 0));
    vecs.push_back(mk(1, 5'b01101, 1, 0, 0,  1, 1, 5'b11000, 0, 0, 0));
    vecs.push_back(mk(1, 5'b01101, 0, 0, 0,  1, 1, 5'b11001, 1, 0, 0));
    vecs.push_back(mk(1, 5'b01101, 0, 0, 0,  0, 1, 5'b01101, 0, 0, 0));
    vecs.push_back(mk(0, 5'b00000, 0, 0, 0,  0, 0, 5'b00000, 0, 0, 0));
    // lead-in to reset mid-INT1
    vecs.push_back(mk(0, 5'b00000, 0, 0, 1,  0, 0, 5'b00000, 0, 0, 0));
    vecs.push_back(mk(0, 5'b00000, 0, 0, 0,  1, 1, 5'b11110, 0, 0, 0));
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; fetchValid = 0; fetchOpcode = 5'b00000;
    stall = 0; flush = 0; intReq = 0;
    model_reset();
    #1;
    chk("reset.outs", 32'(outs()), 32'd0);
    chk("reset.fetchStall", 32'(fetchStall), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      vec_t v;
      string tag;
      v   = vecs[i];
      tag = $sformatf("vec%0d", i);
      fetchValid = v.fv; fetchOpcode = v.op; stall = v.st; flush = v.fl; intReq = v.ir;
      #1;
      chk({tag, ".fetchStall"}, 32'(fetchStall), 32'(v.efs));
      chk({tag, ".model_fetchStall"}, 32'(fetchStall), 32'(model_fstall()));
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk({tag, ".outs"}, 32'(outs()),
          32'({v.ev, v.eop, v.ep, v.eb, v.ea}));
      chk({tag, ".model_outs"}, 32'(outs()), 32'(mouts()));
    end

    // Now in INT1: asynchronous reset mid-cycle drops the owed part
    fetchValid = 0; stall = 0; flush = 0; intReq = 0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset.outs", 32'(outs()), 32'd0);
    chk("midreset.fetchStall", 32'(fetchStall), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(0, 5'b00000, 0, 0, 0, $sformatf("postreset%0d", k));
      chk($sformatf("postreset%0d.noinject", k), 32'(outs()), 32'd0);
    end

    // Random phase with occasional asynchronous resets
    for (int n = 0; n < 600; n++) begin
      logic [4:0] op;
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0:       op = 5'b11000;
          1:       op = 5'b11010;
          default: op = 5'b11100;
        endcase
      end else begin
        op = 5'($urandom_range(0, 31));
      end
      step(($urandom_range(0, 9) < 8), op, ($urandom_range(0, 9) < 2),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0),
           $sformatf("rnd%0d", n));
      if ($urandom_range(0, 99) == 0) begin
        fetchValid = 0; stall = 0; flush = 0; intReq = 0;
        #2;
        rst_n = 1'b0;
        #1;
        chk($sformatf("rnd%0d.asyncreset", n), 32'(outs()), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_micro_op_sequencer
`default_nettype wire

// File: doc/micro_op_sequencer.md
# micro_op_sequencer

Registered IF/ID-boundary sequencer for the 5-bit-opcode pipelined core. It passes fetched opcodes to decode one cycle later and expands two-part instructions (CALL, RET, RTI) into their second micro-op. It injects the two-part interrupt sequence at instruction boundaries and emits flush bubbles, holding fetch as needed. Its issued opcode/bubble pair feeds the combinational control decoder directly, replacing the ad-hoc bubble and second-part logic.

## Interface
- OPC_W, 5, opcode width.
- CALL_OPC, 5'b11000, CALL first part; second part = CALL_OPC+1.
- RET_OPC, 5'b11010, RET first part; second part = RET_OPC+1.
- RTI_OPC, 5'b11100, RTI first part; second part = RTI_OPC+1.
- INT_OPC, 5'b11110, interrupt first part; second part = INT_OPC+1.
- NOP_OPC, 5'b00000, opcode driven when nothing is issued.
- FLUSH_BUBBLES, 1, bubble cycles after flush; legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fetchValid  in  1  fetchOpcode is a real instruction.
- fetchOpcode  in  OPC_W  opcode from fetch.
- stall  in  1  downstream hazard hold.
- flush  in  1  taken branch from a later stage; squash younger work.
- intReq  in  1  external interrupt request (pulse or level).
- fetchStall  out  1  hold PC/fetch this cycle (combinational).
- issueValid  out  1  issueOpcode is a real micro-op.
- issueOpcode  out  OPC_W  micro-op to decoder.
- issuePart  out  1  0 = first/only part, 1 = second part.
- bubble  out  1  decoder must force a bubble (makeMeBubble).
- intAck  out  1  one-cycle pulse when INT second part issues.

## Operation
- States:
  - ISSUE: pass-through.
  - PART2: owe the second part of CALL, RET or RTI.
  - INT1: owe the interrupt second part.
  - FLUSH: emitting bubbles; bubble counter cnt.
- Pending latch:
  - intPend is set on any cycle with intReq=1.
  - It is cleared only when intAck fires.
  - A repeated request while pending merges into the same interrupt.
- takeInt = state==ISSUE && intPend && !stall && !flush.
- Priority per edge: reset > flush > stall > normal.
- flush:
  - Next state is FLUSH with cnt=FLUSH_BUBBLES-1.
  - Registered outputs become issueValid=0, bubble=1, opcode NOP_OPC.
  - Any owed PART2 or INT1 work is squashed.
  - intPend stays set, so a squashed interrupt is retaken later.
- stall (no flush): state, cnt and all registered outputs hold.
- ISSUE, no stall or flush:
  - If takeInt: issue INT_OPC with part 0, go to INT1.
  - Else if fetchValid: issue fetchOpcode with part 0. If the opcode is ∈ {CALL_OPC, RET_OPC, RTI_OPC}, go to PART2.
  - Else: issueValid=0, opcode NOP_OPC, bubble=0.
- PART2: issue (previous opcode)+1 with part 1, return to ISSUE. The fetched opcode is ignored.
- INT1: issue INT_OPC+1 with part 1, pulse intAck, clear intPend, return to ISSUE.
- FLUSH:
  - Emit a bubble each cycle.
  - When cnt==0 and not stalled, return to ISSUE. Otherwise decrement cnt.
  - Interrupts are taken only after FLUSH ends.
- fetchStall = stall | (state==PART2) | (state==INT1) | takeInt. The flush term is excluded; fetch is redirecting.
- Interrupts are never taken between parts of a two-part instruction.

## Timing
- Reset values: state ISSUE, issueValid 0, issueOpcode NOP_OPC, issuePart 0, bubble 0, intAck 0, intPend 0, cnt 0. fetchStall=0 after reset with stall=0.
- Latency: an opcode presented in cycle t appears on issue outputs after edge t+1.
- A two-part instruction occupies 2 issue cycles, with fetchStall high for 1 cycle.
- An interrupt occupies 2 issue cycles, with fetchStall high for 2 cycles (takeInt cycle, then INT1).
- An intReq pulse at edge e can be taken in the cycle after e at the earliest.
- Flush produces exactly FLUSH_BUBBLES bubble cycles when no stall occurs. Each stall cycle extends FLUSH by one cycle.
- Reset asserted mid-sequence drops owed parts and pending interrupts immediately, without waiting for a clock edge.
- Opcode +1 wraps within OPC_W. This cannot occur with the default parameters.

## Structure
- Shared package cpu_pkg holds:
  - opcode constants: NOP, CALL, RET, RTI, INT and their +1 forms, shared with the control decoder;
  - seq_state_t enum {ISSUE, PART2, INT1, FLUSH}.
- No sub-module; the flush counter and pending latch are inline.

## Test plan
- Sequence ADD(01001), CALL(11000), SUB(01010) with fetchValid=1 → issueOpcode 01001, 11000(part0), 11001(part1), 01010; fetchStall=1 only in the cycle 11000 is on the output.
- intReq pulse while issuing RET part 0 → 11010, 11011, then 11110, 11111; intAck single pulse with 11111; the fetched instruction reissued next.
- flush in PART2 after CALL, FLUSH_BUBBLES=2 → 11001 never issued; 2 cycles bubble=1, issueValid=0; then normal fetch.
- flush while in INT1 → 11111 not issued, intAck=0, intPend stays 1; after FLUSH, 11110 then 11111 with intAck=1.
- stall held 3 cycles during PART2 → outputs frozen at 11000 for 3 cycles; 11001 issued once after release.
- rst_n low mid-INT1 → all outputs at reset values asynchronously; intAck never fires; no injection after release.
